// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS main control FSM with memory handshake, stall watchdog,
// trap state and retired-instruction counter.
module mc_ctrl_fsm #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUop,
    output logic [1:0]       PCSource,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB, TRAP
    } state_t;

    // wait_cnt never needs to exceed TIMEOUT-1: at that value a further stall traps
    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    state_t state, next;
    logic [WW-1:0] wait_cnt;
    logic [1:0] cause_nxt;

    always_comb begin
        next        = state;
        cause_nxt   = trap_cause;
        mem_req     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUop       = 3'd0;
        PCSource    = 2'b00;
        trap        = 1'b0;
        case (state)
            RST:    next = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
                next    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    6'h00:        next = EXEC;
                    6'h23, 6'h2B: next = MEMADR;
                    6'h04:        next = BRANCH;
                    6'h02:        next = JUMP;
                    6'h08:        next = ADDIEX;
                    default: begin
                        next      = TRAP;
                        cause_nxt = 2'b01;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = opcode == 6'h23 ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
                next    = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                next     = FETCH;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
                next     = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = 3'd2;
                next    = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                next     = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 3'd1;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                next        = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                next     = FETCH;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
                next     = FETCH;
            end
            TRAP:    trap = 1'b1;
            default: next = RST;
        endcase
        // a completing access in the final allowed cycle wins over the watchdog
        if (mem_req && !mem_ready && TIMEOUT != 0 && wait_cnt == LIMIT) begin
            next      = TRAP;
            cause_nxt = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RST;
            wait_cnt    <= '0;
            trap_cause  <= 2'b00;
            instr_count <= '0;
        end else begin
            state      <= next;
            trap_cause <= cause_nxt;
            wait_cnt   <= next != state ? '0 : (mem_req && !mem_ready) ? wait_cnt + WW'(1) : wait_cnt;
            if (next == FETCH && state != FETCH && state != RST)
                instr_count <= instr_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed bench for mc_ctrl_fsm; an instruction-sequence model predicts
// every output each cycle, and literal checks pin the key spec scenarios.
module tb_mc_ctrl_fsm;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] opcode;
    logic mem_ready;
    logic mem_req, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic MemtoReg, RegDst, RegWrite, ALUSrcA, trap;
    logic [1:0] ALUSrcB, PCSource, trap_cause;
    logic [2:0] ALUop;
    logic [3:0] instr_count;
    logic [20:0] dv;

    int n_cmp = 0;
    int n_bad = 0;
    bit run = 0;

    mc_ctrl_fsm #(.CNT_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUop(ALUop), .PCSource(PCSource), .trap(trap), .trap_cause(trap_cause),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign dv = {mem_req, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, trap, trap_cause};

    // Model: an instruction is a list of steps chosen by opcode; memory steps wait for mem_ready.
    int mi = -1;
    int mst = 0;
    bit mtrap = 0;
    logic [1:0] mcause = 2'b00;
    logic [3:0] mcnt = 4'd0;

    function automatic string seq(logic [5:0] op, int i);
        if (i == 0) return "FETCH";
        if (i == 1) return "DECODE";
        case (op)
            6'h00:   return i == 2 ? "EXEC" : "RWB";
            6'h23:   return i == 2 ? "MEMADR" : i == 3 ? "MEMRD" : "MEMWB";
            6'h2B:   return i == 2 ? "MEMADR" : "MEMWR";
            6'h04:   return "BRANCH";
            6'h02:   return "JUMP";
            6'h08:   return i == 2 ? "ADDIEX" : "ADDIWB";
            default: return "TRAP";
        endcase
    endfunction

    function automatic int seq_len(logic [5:0] op);
        case (op)
            6'h00, 6'h2B, 6'h08: return 4;
            6'h23:               return 5;
            default:             return 3;
        endcase
    endfunction

    function automatic string step_now();
        return mtrap ? "TRAP" : mi < 0 ? "RST" : seq(opcode, mi);
    endfunction

    function automatic bit is_mem(string s);
        return s == "FETCH" || s == "MEMRD" || s == "MEMWR";
    endfunction

    function automatic logic [20:0] expv(string s, logic r, logic [1:0] c);
        logic q, pw, pc, id, mr, mw, iw, mt, rd, rw, sa, tr;
        logic [1:0] sb, ps, tc;
        logic [2:0] ao;
        {q, pw, pc, id, mr, mw, iw, mt, rd, rw, sa, tr} = '0;
        sb = 2'b00; ps = 2'b00; tc = 2'b00; ao = 3'd0;
        if (s == "FETCH") begin q = 1; mr = 1; sb = 2'b01; pw = r; iw = r; end
        else if (s == "DECODE") sb = 2'b11;
        else if (s == "MEMADR" || s == "ADDIEX") begin sa = 1; sb = 2'b10; end
        else if (s == "MEMRD") begin q = 1; mr = 1; id = 1; end
        else if (s == "MEMWR") begin q = 1; mw = 1; id = 1; end
        else if (s == "MEMWB") begin rw = 1; mt = 1; end
        else if (s == "EXEC") begin sa = 1; ao = 3'd2; end
        else if (s == "RWB") begin rw = 1; rd = 1; end
        else if (s == "ADDIWB") rw = 1;
        else if (s == "BRANCH") begin sa = 1; ao = 3'd1; pc = 1; ps = 2'b01; end
        else if (s == "JUMP") begin pw = 1; ps = 2'b10; end
        else if (s == "TRAP") begin tr = 1; tc = c; end
        return {q, pw, pc, id, mr, mw, iw, mt, rd, rw, sa, sb, ao, ps, tr, tc};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mi <= -1; mst <= 0; mtrap <= 0; mcause <= 2'b00; mcnt <= 4'd0;
        end else if (mtrap) begin
            mtrap <= 1;
        end else if (mi < 0) begin
            mi <= 0; mst <= 0;
        end else if (is_mem(step_now()) && !mem_ready) begin
            if (mst == TO - 1) begin mtrap <= 1; mcause <= 2'b10; end
            else mst <= mst + 1;
        end else if (seq(opcode, mi + 1) == "TRAP") begin
            mtrap <= 1; mcause <= 2'b01;
        end else begin
            mst <= 0;
            if (mi + 1 == seq_len(opcode)) begin mi <= 0; mcnt <= mcnt + 4'd1; end
            else mi <= mi + 1;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            n_cmp++;
            if ({dv, instr_count} !== {expv(step_now(), mem_ready, mcause), mcnt}) begin
                n_bad++;
                $display("FAIL cycle t=%0t step=%s: got outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                         $time, step_now(), dv, instr_count, expv(step_now(), mem_ready, mcause), mcnt);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1; mem_ready = 1; opcode = 6'h00;
        #2 rst_n = 0;
        #1 run = 1;
        chk("reset_outs", 32'(dv), 0);
        chk("reset_cnt", 32'(instr_count), 0);
        @(posedge clk); #1 rst_n = 1;
        tick(3);
        chk("add_exec_aluop", 32'(ALUop), 2);
        tick(2);
        chk("add_retire", 32'(instr_count), 1);
        opcode = 6'h23;
        tick(2);
        mem_ready = 0;
        tick(1);
        chk("lw_memrd_first", 32'({MemRead, IorD}), 3);
        tick(3);
        chk("lw_memrd_held", 32'({MemRead, IorD, mem_req}), 7);
        mem_ready = 1;
        tick(1);
        chk("lw_memwb", 32'({RegWrite, MemtoReg}), 3);
        tick(1);
        chk("lw_retire", 32'(instr_count), 2);
        opcode = 6'h04;
        tick(2);
        chk("beq_branch", 32'({ALUop, PCWriteCond, PCSource}), 32'b001_1_01);
        tick(1);
        opcode = 6'h02;
        tick(2);
        chk("j_jump", 32'({PCWrite, PCSource}), 32'b1_10);
        tick(1);
        chk("j_retire", 32'(instr_count), 4);
        opcode = 6'h2B;
        tick(4);
        opcode = 6'h08;
        tick(4);
        chk("sw_addi_retire", 32'(instr_count), 6);
        mem_ready = 0;
        tick(3);
        mem_ready = 1;
        tick(1);
        chk("late_ready_no_trap", 32'({trap, ALUSrcB}), 32'b0_11);
        tick(3);
        opcode = 6'h00;
        for (int i = 0; i < 10; i++) tick(4);
        chk("count_wrap", 32'(instr_count), 1);
        opcode = 6'h2B;
        tick(2);
        mem_ready = 0;
        tick(1);
        chk("sw_memwr", 32'(MemWrite), 1);
        #2 rst_n = 0;
        #1 chk("reset_mid_memwr", 32'({MemWrite, mem_req, instr_count}), 0);
        @(posedge clk); #1 rst_n = 1;
        tick(4);
        chk("fetch_stall_4", 32'(trap), 0);
        tick(1);
        chk("timeout_trap", 32'({trap, trap_cause}), 32'b1_10);
        rst_n = 0; opcode = 6'h3F; mem_ready = 1;
        #1 chk("reset_clears_trap", 32'({trap, trap_cause}), 0);
        @(posedge clk); #1 rst_n = 1;
        tick(3);
        chk("illegal_trap", 32'({trap, trap_cause}), 32'b1_01);
        tick(20);
        chk("trap_sticky", 32'({trap, mem_req}), 32'b10);
        rst_n = 0;
        #1 chk("trap_reset", 32'(trap), 0);
        @(posedge clk); #1 rst_n = 1; opcode = 6'h00;
        tick(5);
        chk("after_trap_add", 32'(instr_count), 1);
        run = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
